// File: rtl/ddr3_byte_bridge_pkg.sv
// rtl/ddr3_byte_bridge_pkg.sv - shared state type, line geometry and byte-select helper for the DDR3 byte bridge
package ddr3_byte_bridge_pkg;

  localparam int DDR3_LINE_BYTES = 8;
  localparam int DDR3_LINE_BITS  = DDR3_LINE_BYTES * 8;
  localparam int DDR3_TAG_W      = 25;

  typedef enum logic [2:0] {
    IDLE,
    HIT,
    RD_REQ,
    RD_WAIT,
    WR_REQ
  } ddr3_bridge_state_t;

  function automatic logic [7:0] line_byte(input logic [DDR3_LINE_BITS-1:0] line,
                                           input logic [2:0]                sel);
    return line[{sel, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/ddr3_line_cache.sv
// rtl/ddr3_line_cache.sv - single 8-byte read line with tag, valid, fill, flush and write handling
// Macro DDR3_CACHE_UPDATE_EN: a write hitting the line patches the byte; otherwise it invalidates the line.
module ddr3_line_cache
  import ddr3_byte_bridge_pkg::*;
(
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      flush,
  input  logic                      fill,
  input  logic [DDR3_LINE_BITS-1:0] fill_line,
  input  logic [DDR3_TAG_W-1:0]     fill_tag,
  input  logic                      wr,
  input  logic [DDR3_TAG_W-1:0]     wr_tag,
  input  logic [2:0]                wr_sel,
  input  logic [7:0]                wr_byte,
  input  logic [DDR3_TAG_W-1:0]     look_tag,
  input  logic [2:0]                look_sel,
  output logic                      hit,
  output logic [7:0]                look_byte
);

  logic [DDR3_LINE_BITS-1:0] line;
  logic [DDR3_TAG_W-1:0]     tag;
  logic                      valid;
  logic                      wr_match;

  assign hit       = valid && (tag == look_tag);
  assign look_byte = line_byte(line, look_sel);
  assign wr_match  = wr && valid && (tag == wr_tag);

`ifndef DDR3_CACHE_UPDATE_EN
  logic unused_wr;
  assign unused_wr = ^{wr_sel, wr_byte};
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      line  <= '0;
      tag   <= '0;
      valid <= 1'b0;
    end else begin
      if (fill) begin
        line  <= fill_line;
        tag   <= fill_tag;
        valid <= 1'b1;
      end else if (wr_match) begin
`ifdef DDR3_CACHE_UPDATE_EN
        line[{wr_sel, 3'b000} +: 8] <= wr_byte;
`else
        valid <= 1'b0;
`endif
      end
      // A flush landing on the fill cycle still leaves the line invalid.
      if (flush) valid <= 1'b0;
    end
  end

endmodule

// File: rtl/ddr3_byte_bridge.sv
// rtl/ddr3_byte_bridge.sv - byte-wide command front end onto the 64-bit DDRAM port, with one-line read cache
// Macro DDR3_CACHE_UPDATE_EN (in ddr3_line_cache) selects write-patch versus write-invalidate of the cached line.
module ddr3_byte_bridge
  import ddr3_byte_bridge_pkg::*;
#(
  parameter logic [3:0] DDR3_BASE = 4'h3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [27:0] ddr3_addr,
  input  logic        ddr3_rd,
  input  logic        ddr3_wr,
  input  logic [7:0]  ddr3_din,
  input  logic        ddr3_request,
  output logic [7:0]  ddr3_dout,
  output logic        ddr3_ready,
  input  logic        cache_flush,
  input  logic        DDRAM_BUSY,
  output logic [7:0]  DDRAM_BURSTCNT,
  output logic [28:0] DDRAM_ADDR,
  input  logic [63:0] DDRAM_DOUT,
  input  logic        DDRAM_DOUT_READY,
  output logic        DDRAM_RD,
  output logic [63:0] DDRAM_DIN,
  output logic [7:0]  DDRAM_BE,
  output logic        DDRAM_WE
);

  ddr3_bridge_state_t state;
  logic               ready_q;
  logic               rd_pending;
  logic [27:0]        addr_q;
  logic               accept;
  logic               hit;
  logic               fill;
  logic [7:0]         hit_byte;
  logic [7:0]         fill_byte;

  // A read already handed to the controller must have its data drained even across reset.
  assign ddr3_ready     = ready_q & ~rd_pending;
  assign accept         = ddr3_ready & ddr3_request & (ddr3_rd | ddr3_wr) & (state == IDLE);
  assign fill           = (state == RD_WAIT) & DDRAM_DOUT_READY;
  assign fill_byte      = line_byte(DDRAM_DOUT, addr_q[2:0]);
  assign DDRAM_BURSTCNT = 8'd1;
  assign DDRAM_ADDR     = {DDR3_BASE, addr_q[27:3]};

  ddr3_line_cache u_cache (
    .clk       (clk),
    .reset     (reset),
    .flush     (cache_flush),
    .fill      (fill),
    .fill_line (DDRAM_DOUT),
    .fill_tag  (addr_q[27:3]),
    .wr        (accept & ddr3_wr),
    .wr_tag    (ddr3_addr[27:3]),
    .wr_sel    (ddr3_addr[2:0]),
    .wr_byte   (ddr3_din),
    .look_tag  (ddr3_addr[27:3]),
    .look_sel  (addr_q[2:0]),
    .hit       (hit),
    .look_byte (hit_byte)
  );

  always_ff @(posedge clk) begin
    if (DDRAM_DOUT_READY) rd_pending <= 1'b0;
    else if (DDRAM_RD && !DDRAM_BUSY) rd_pending <= 1'b1;

    if (reset) begin
      state     <= IDLE;
      ready_q   <= 1'b1;
      ddr3_dout <= 8'h00;
      addr_q    <= '0;
      DDRAM_RD  <= 1'b0;
      DDRAM_WE  <= 1'b0;
      DDRAM_BE  <= 8'h00;
      DDRAM_DIN <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            ready_q <= 1'b0;
            addr_q  <= ddr3_addr;
            if (ddr3_wr) begin
              state     <= WR_REQ;
              DDRAM_WE  <= 1'b1;
              DDRAM_BE  <= 8'd1 << ddr3_addr[2:0];
              DDRAM_DIN <= {DDR3_LINE_BYTES{ddr3_din}};
            end else if (hit) begin
              state <= HIT;
            end else begin
              state    <= RD_REQ;
              DDRAM_RD <= 1'b1;
            end
          end
        end
        HIT: begin
          ddr3_dout <= hit_byte;
          ready_q   <= 1'b1;
          state     <= IDLE;
        end
        RD_REQ: begin
          if (!DDRAM_BUSY) begin
            DDRAM_RD <= 1'b0;
            state    <= RD_WAIT;
          end
        end
        RD_WAIT: begin
          if (DDRAM_DOUT_READY) begin
            ddr3_dout <= fill_byte;
            ready_q   <= 1'b1;
            state     <= IDLE;
          end
        end
        WR_REQ: begin
          if (!DDRAM_BUSY) begin
            DDRAM_WE <= 1'b0;
            DDRAM_BE <= 8'h00;
            ready_q  <= 1'b1;
            state    <= IDLE;
          end
        end
        default: begin
          state   <= IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

endmodule
